spi_master_shift: RTL and testbench

SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits directly upstream of the d_ff-based SPI slave shift register: generates SS_N, SCLK and MOSI, and captures MISO.
- Converts one parallel word per START into a framed serial transaction.
- Returns the received word with a one-cycle DONE pulse.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clk_div.sv | 31 +++
 rtl/spi_master_shift.sv | 108 ++++++++++
 tb/tb_spi_master_shift.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Constants shared by the SPI master engine and the slave-side shift register.
// Holds the mode settings, the frame state encoding and a counter-width helper.
package spi_pkg;

    localparam bit CPOL      = 1'b0;
    localparam bit CPHA      = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LEAD  = ST_LEAD,
        SHIFT = ST_SHIFT,
        TRAIL = ST_TRAIL
    } spi_state_e;

    // Counter width that stays at least one bit when the count range is 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: TICK pulses on the last cycle of every CLK_DIV-cycle
// window while enabled; the count is held at zero while disabled.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int              CW   = cnt_w(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign TICK = EN && (cnt_q == LAST);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cnt_q <= '0;
        end else if (!EN || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_shift.sv
// SPI master shift engine, mode 0, MSB first: one parallel word per START becomes
// a framed serial transfer; the received word is returned with a DONE pulse.
module spi_master_shift
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              SS_N,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int BW = $clog2(DATA_W + 1);

    spi_state_e        state_q;
    logic [DATA_W-1:0] tx_sr_q;
    logic [DATA_W-1:0] rx_sr_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              busy_q, done_q, ss_n_q, sclk_q, mosi_q;
    logic              tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .CLK  (CLK),
        .CLR  (CLR),
        .EN   (state_q != IDLE),
        .TICK (tick)
    );

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RX_DATA = rx_data_q;
    assign SS_N    = ss_n_q;
    assign SCLK    = sclk_q ^ CPOL;
    assign MOSI    = mosi_q;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy_q is still high in the DONE cycle, so START is ignored there.
                    busy_q <= 1'b0;
                    if (START && !busy_q) begin
                        tx_sr_q   <= TX_DATA;
                        rx_sr_q   <= '0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        ss_n_q    <= 1'b0;
                        mosi_q    <= TX_DATA[DATA_W-1];
                        state_q   <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            rx_sr_q <= {rx_sr_q[DATA_W-2:0], MISO};
                        end else begin
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q < BW'(DATA_W - 1)) begin
                                tx_sr_q <= tx_sr_q << 1;
                                mosi_q  <= tx_sr_q[DATA_W-2];
                            end else begin
                                state_q <= TRAIL;
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        ss_n_q    <= 1'b1;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sr_q;
                        mosi_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_shift.sv
// Randomized scoreboard bench for spi_master_shift: channel 0 runs CLK_DIV=2 against
// a slave model, channel 1 runs CLK_DIV=1 with MISO looped back from MOSI.
module tb_spi_master_shift;

    typedef struct {
        int         ch;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       start [2];
    logic [7:0] tx    [2];
    logic       busy  [2];
    logic       done  [2];
    logic [7:0] rx    [2];
    logic       ss_n  [2];
    logic       sclk  [2];
    logic       mosi  [2];
    logic       miso  [2];

    int         nvec = 0;
    int         nerr = 0;
    exp_t       q[$];
    logic [7:0] slv_word = 8'h00;
    int         srise = 0;

    always #5 CLK = ~CLK;

    spi_master_shift #(.DATA_W(8), .CLK_DIV(2)) u_dut0 (
        .CLK(CLK), .CLR(CLR), .START(start[0]), .TX_DATA(tx[0]), .BUSY(busy[0]),
        .DONE(done[0]), .RX_DATA(rx[0]), .SS_N(ss_n[0]), .SCLK(sclk[0]),
        .MOSI(mosi[0]), .MISO(miso[0])
    );

    spi_master_shift #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
        .CLK(CLK), .CLR(CLR), .START(start[1]), .TX_DATA(tx[1]), .BUSY(busy[1]),
        .DONE(done[1]), .RX_DATA(rx[1]), .SS_N(ss_n[1]), .SCLK(sclk[1]),
        .MOSI(mosi[1]), .MISO(miso[1])
    );

    // Mode-0 slave: presents bit 7-k of its word until the k-th SCLK rise of the frame.
    always @(negedge ss_n[0]) srise = 0;
    always @(posedge sclk[0]) srise = srise + 1;
    assign miso[0] = (srise < 8) ? slv_word[3'(7 - srise)] : 1'b0;
    assign miso[1] = mosi[1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: rebuilds each frame from the pins and scores it at DONE.
    logic       prev_ss   [2] = '{1'b1, 1'b1};
    logic       prev_sclk [2] = '{1'b0, 1'b0};
    logic [7:0] last_rx   [2] = '{8'h00, 8'h00};
    logic [7:0] mw        [2];
    int         low [2], rises [2], hi [2], lo [2];

    always @(negedge CLK) begin
        for (int c = 0; c < 2; c++) begin
            int dv;
            dv = (c == 0) ? 2 : 1;
            if (!CLR) begin
                prev_ss[c] = 1'b1; prev_sclk[c] = 1'b0; last_rx[c] = 8'h00;
                low[c] = 0; rises[c] = 0; hi[c] = 0; lo[c] = 0; mw[c] = 8'h00;
            end else begin
                if (!ss_n[c] && prev_ss[c]) begin
                    low[c] = 0; rises[c] = 0; hi[c] = 0; lo[c] = 0; mw[c] = 8'h00;
                end
                if (!ss_n[c]) low[c]++;
                if (sclk[c] && !prev_sclk[c]) begin
                    if (rises[c] > 0) chk($sformatf("ch%0d sclk_low_phase", c), lo[c], dv);
                    rises[c]++;
                    mw[c] = {mw[c][6:0], mosi[c]};
                    hi[c] = 1;
                end else if (sclk[c]) begin
                    hi[c]++;
                end
                if (!sclk[c] && prev_sclk[c]) begin
                    chk($sformatf("ch%0d sclk_high_phase", c), hi[c], dv);
                    lo[c] = 1;
                end else if (!sclk[c]) begin
                    lo[c]++;
                end
                if (done[c]) begin
                    chk($sformatf("ch%0d busy_in_done", c), busy[c], 1);
                    chk($sformatf("ch%0d ss_n_in_done", c), ss_n[c], 1);
                    if (q.size() == 0) begin
                        chk($sformatf("ch%0d spurious_done", c), 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk($sformatf("ch%0d done_channel", c), c, e.ch);
                        chk($sformatf("ch%0d mosi_word", c), mw[c], e.tx);
                        chk($sformatf("ch%0d rx_data", c), rx[c], e.rx);
                        chk($sformatf("ch%0d ss_low_cycles", c), low[c], (2 * 8 + 2) * dv);
                        chk($sformatf("ch%0d sclk_rises", c), rises[c], 8);
                    end
                    last_rx[c] = rx[c];
                end else begin
                    chk($sformatf("ch%0d rx_stable", c), rx[c], last_rx[c]);
                end
                prev_ss[c]   = ss_n[c];
                prev_sclk[c] = sclk[c];
            end
        end
    end

    task automatic wait_idle(input int c);
        int n;
        n = 0;
        while (busy[c] !== 1'b0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) chk($sformatf("ch%0d wait_idle_timeout", c), 1, 0);
    endtask

    task automatic wait_done(input int c);
        int n;
        n = 0;
        while (done[c] !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) chk($sformatf("ch%0d wait_done_timeout", c), 1, 0);
    endtask

    task automatic xfer(input int c, input logic [7:0] d, input logic [7:0] s);
        exp_t e;
        wait_idle(c);
        tx[c] = d;
        if (c == 0) slv_word = s;
        e.ch = c;
        e.tx = d;
        e.rx = (c == 1) ? d : s;
        q.push_back(e);
        start[c] = 1'b1;
        @(negedge CLK);
        start[c] = 1'b0;
    endtask

    initial begin
        start[0] = 1'b0; start[1] = 1'b0;
        tx[0] = 8'h00;   tx[1] = 8'h00;
        repeat (3) @(negedge CLK);
        CLR = 1'b1;

        // Idle after reset, nothing requested.
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            for (int c = 0; c < 2; c++)
                chk($sformatf("ch%0d idle_outputs", c),
                    {ss_n[c], sclk[c], mosi[c], busy[c], done[c], rx[c]}, {5'b10000, 8'h00});
        end

        // Basic frame.
        xfer(0, 8'hA5, 8'h3C);
        wait_idle(0);

        // Back-to-back with START held; TX_DATA changes after acceptance.
        begin
            exp_t e;
            tx[0] = 8'hFF; slv_word = 8'h3C; start[0] = 1'b1;
            e.ch = 0; e.tx = 8'hFF; e.rx = 8'h3C; q.push_back(e);
            @(negedge CLK);
            tx[0] = 8'h00;
            e.tx = 8'h00; q.push_back(e);
            wait_done(0);
            @(negedge CLK);
            wait_idle(0);
            for (int n = 0; n < 10 && busy[0] !== 1'b1; n++) @(negedge CLK);
            chk("b2b_second_accept", busy[0], 1);
            start[0] = 1'b0;
            wait_idle(0);
        end

        // START pulse mid-frame must be ignored.
        xfer(0, 8'h81, 8'hE7);
        repeat (9) @(negedge CLK);
        tx[0] = 8'h7E; start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        wait_idle(0);

        // Randomized frames with random gaps.
        for (int i = 0; i < 20; i++) begin
            xfer(0, 8'($urandom), 8'($urandom));
            wait_idle(0);
            repeat ($urandom_range(0, 4)) @(negedge CLK);
        end

        // Reset after the 4th SCLK rise: partial frame discarded.
        xfer(0, 8'h96, 8'h5A);
        for (int n = 0; n < 100 && srise < 4; n++) @(negedge CLK);
        chk("reached_4th_rise", (srise >= 4), 1);
        #2;
        CLR = 1'b0;
        q.delete();
        #1;
        chk("midreset_outputs", {ss_n[0], sclk[0], mosi[0], busy[0], done[0], rx[0]},
            {5'b10000, 8'h00});
        repeat (3) @(negedge CLK);
        CLR = 1'b1;
        xfer(0, 8'h55, 8'hAA);
        wait_idle(0);

        // Divider corner, loopback.
        xfer(1, 8'hC3, 8'h00);
        for (int i = 0; i < 6; i++) xfer(1, 8'($urandom), 8'h00);
        wait_idle(1);

        repeat (5) @(negedge CLK);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
